stopwatch_run_ctrl: RTL and testbench

- Run/pause/clear sequencer for the stopwatch/timer counter datapath. Clocked by the 1 kHz ms clock.
- Debounces and edge-detects the raw start/stop and clear buttons, synchronises the mode switches, and issues count-enable, clear and load commands.
- Stops the count when the datapath reports its terminal value (99.99 up / 00.00 down).
- Replaces the simple button controller in the top level; the datapath consumes its outputs directly.

---
 rtl/stopwatch_run_ctrl.sv | 156 +++++++++++++++
 tb/tb_stopwatch_run_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : stopwatch_run_ctrl
//  Brief    : Run/pause/clear sequencer for the stopwatch counter datapath.
//             Synchronises and debounces the raw buttons and mode switches,
//             then drives count-enable, clear/load pulses and done status.
//  Revision : 1.0  initial release
// ============================================================================
module stopwatch_run_ctrl #(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       startStopButton,
    input  logic       clearButton,
    input  logic [1:0] mode,
    input  logic       atLimit,
    output logic       cntEn,
    output logic       clrPulse,
    output logic       loadPulse,
    output logic       countDown,
    output logic       done,
    output logic [2:0] state
);

    localparam int              CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Synchroniser bit order: {mode[1], mode[0], clearButton, startStopButton}
    logic [3:0] sync_q [SYNC_STAGES];
    logic [3:0] sync_out;
    logic [1:0] sync_btn;
    logic [1:0] mode_sync;
    logic [1:0] press_w;      // [0] start/stop press, [1] clear press

    state_t     state_q, state_d;
    logic [1:0] mode_q, mode_d;
    logic       cnt_en_q, cnt_en_d;
    logic       done_q, done_d;
    logic       mode_chg;
    logic       clr_ev;
    logic       start_ev;

    // Multi-stage synchroniser for every asynchronous input
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= {mode, clearButton, startStopButton};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign sync_out  = sync_q[SYNC_STAGES-1];
    assign sync_btn  = sync_out[1:0];
    assign mode_sync = sync_out[3:2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_debounce
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             level_q, level_d;
        logic             level_prev_q;

        // Level is accepted only after DEBOUNCE_CYCLES consecutive differing samples
        always_comb begin
            cnt_d   = cnt_q;
            level_d = level_q;
            if (sync_btn[gi] == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // Debounce state and previous level for rising-edge detection
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q        <= '0;
                level_q      <= 1'b0;
                level_prev_q <= 1'b0;
            end else begin
                cnt_q        <= cnt_d;
                level_q      <= level_d;
                level_prev_q <= level_q;
            end
        end

        // Only a 0->1 debounced transition is an event; releases are ignored
        assign press_w[gi] = level_q & ~level_prev_q;
    end

    assign start_ev = press_w[0];
    assign mode_chg = (mode_sync != mode_q);
    assign clr_ev   = press_w[1] | mode_chg;

    // Next-state logic; clear/mode change outranks start, which outranks atLimit
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        if (clr_ev) begin
            state_d = S_INIT;
            mode_d  = mode_sync;
        end else begin
            case (state_q)
                S_INIT:  state_d = S_IDLE;
                S_IDLE:  if (start_ev) state_d = atLimit ? S_DONE : S_RUN;
                S_RUN: begin
                    if (start_ev)     state_d = S_PAUSE;
                    else if (atLimit) state_d = S_DONE;
                end
                S_PAUSE: if (start_ev) state_d = S_RUN;
                S_DONE:  state_d = S_DONE;
                default: state_d = S_INIT;
            endcase
        end
        // Outputs follow the next state so cntEn drops on the edge entering DONE
        cnt_en_d = (state_d == S_RUN);
        done_d   = (state_d == S_DONE);
    end

    // FSM state, registered mode and Moore outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_INIT;
            mode_q   <= 2'b00;
            cnt_en_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            cnt_en_q <= cnt_en_d;
            done_q   <= done_d;
        end
    end

    // Init pulses are held low while reset is asserted even though state reads INIT
    assign clrPulse  = reset_n & (state_q == S_INIT) & ~mode_q[0];
    assign loadPulse = reset_n & (state_q == S_INIT) &  mode_q[0];
    assign cntEn     = cnt_en_q;
    assign done      = done_q;
    assign countDown = mode_q[1];
    assign state     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stopwatch_run_ctrl
//  Brief    : Directed self-checking bench for stopwatch_run_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_stopwatch_run_ctrl;

    localparam int C_DEB  = 20;
    localparam int C_SYNC = 2;

    logic       clk;
    logic       reset_n;
    logic       startStopButton;
    logic       clearButton;
    logic [1:0] mode;
    logic       atLimit;
    logic       cntEn;
    logic       clrPulse;
    logic       loadPulse;
    logic       countDown;
    logic       done;
    logic [2:0] state;

    int n_checks = 0;
    int n_errors = 0;

    stopwatch_run_ctrl #(
        .DEBOUNCE_CYCLES (C_DEB),
        .SYNC_STAGES     (C_SYNC)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .startStopButton (startStopButton),
        .clearButton     (clearButton),
        .mode            (mode),
        .atLimit         (atLimit),
        .cntEn           (cntEn),
        .clrPulse        (clrPulse),
        .loadPulse       (loadPulse),
        .countDown       (countDown),
        .done            (done),
        .state           (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic saw_en;

        reset_n         = 1'b0;
        startStopButton = 1'b0;
        clearButton     = 1'b0;
        mode            = 2'b00;
        atLimit         = 1'b0;

        // Reset state
        tick(3);
        check_eq("rst_state", state, 3'd0);
        check_eq("rst_cnten", cntEn, 1'b0);
        check_eq("rst_clr",   clrPulse, 1'b0);
        check_eq("rst_load",  loadPulse, 1'b0);
        check_eq("rst_done",  done, 1'b0);
        check_eq("rst_cdown", countDown, 1'b0);

        // Release: one INIT cycle with clrPulse, then IDLE
        reset_n = 1'b1;
        #1;
        check_eq("init_state", state, 3'd0);
        check_eq("init_clr",   clrPulse, 1'b1);
        check_eq("init_load",  loadPulse, 1'b0);
        tick(1);
        check_eq("idle_state", state, 3'd1);
        check_eq("idle_clr",   clrPulse, 1'b0);
        check_eq("idle_cnten", cntEn, 1'b0);
        check_eq("idle_done",  done, 1'b0);

        // Bouncy start press: three short pulses then held
        for (int i = 0; i < 3; i++) begin
            startStopButton = 1'b1; tick(5);
            startStopButton = 1'b0; tick(5);
        end
        startStopButton = 1'b1;
        tick(22);
        check_eq("bounce_pre_en", cntEn, 1'b0);
        check_eq("bounce_pre_st", state, 3'd1);
        tick(1);
        check_eq("bounce_run_en", cntEn, 1'b1);
        check_eq("bounce_run_st", state, 3'd2);
        tick(30);
        check_eq("hold_one_event", state, 3'd2);
        startStopButton = 1'b0;
        tick(30);
        check_eq("release_no_event", state, 3'd2);

        // Second clean press pauses
        startStopButton = 1'b1;
        tick(22);
        check_eq("pause_pre", state, 3'd2);
        tick(1);
        check_eq("pause_st", state, 3'd3);
        check_eq("pause_en", cntEn, 1'b0);
        startStopButton = 1'b0;
        tick(30);

        // mode=10: clear-init, then start with atLimit goes straight to DONE
        mode = 2'b10;
        tick(2);
        check_eq("m10_sync_wait", state, 3'd3);
        tick(1);
        check_eq("m10_init_st",  state, 3'd0);
        check_eq("m10_init_clr", clrPulse, 1'b1);
        check_eq("m10_init_ld",  loadPulse, 1'b0);
        check_eq("m10_cdown",    countDown, 1'b1);
        tick(1);
        check_eq("m10_idle", state, 3'd1);
        atLimit = 1'b1;
        startStopButton = 1'b1;
        saw_en = 1'b0;
        for (int i = 0; i < 23; i++) begin
            tick(1);
            if (cntEn) saw_en = 1'b1;
        end
        check_eq("m10_done_st",  state, 3'd4);
        check_eq("m10_done",     done, 1'b1);
        check_eq("m10_never_en", saw_en, 1'b0);
        startStopButton = 1'b0;
        atLimit = 1'b0;
        tick(30);

        // mode=11: load-init, run, terminal value stops the count
        mode = 2'b11;
        tick(3);
        check_eq("m11_init_st", state, 3'd0);
        check_eq("m11_load",    loadPulse, 1'b1);
        check_eq("m11_clr",     clrPulse, 1'b0);
        check_eq("m11_done0",   done, 1'b0);
        tick(1);
        check_eq("m11_idle", state, 3'd1);
        check_eq("m11_load_once", loadPulse, 1'b0);
        startStopButton = 1'b1;
        tick(23);
        check_eq("m11_run", state, 3'd2);
        startStopButton = 1'b0;
        tick(50);
        check_eq("m11_run_en", cntEn, 1'b1);
        atLimit = 1'b1;
        tick(1);
        check_eq("m11_lim_st",   state, 3'd4);
        check_eq("m11_lim_en",   cntEn, 1'b0);
        check_eq("m11_lim_done", done, 1'b1);
        startStopButton = 1'b1; tick(30);
        startStopButton = 1'b0; tick(30);
        check_eq("m11_start_ignored", state, 3'd4);
        clearButton = 1'b1;
        tick(22);
        check_eq("m11_clr_pre", state, 3'd4);
        tick(1);
        check_eq("m11_clr_init", state, 3'd0);
        check_eq("m11_clr_load", loadPulse, 1'b1);
        check_eq("m11_clr_done", done, 1'b0);
        clearButton = 1'b0;
        atLimit = 1'b0;
        tick(30);
        check_eq("m11_back_idle", state, 3'd1);

        // mode=01 then flip to 00 while running
        mode = 2'b01;
        tick(3);
        check_eq("m01_load", loadPulse, 1'b1);
        check_eq("m01_cdown", countDown, 1'b0);
        tick(1);
        startStopButton = 1'b1;
        tick(23);
        check_eq("m01_run", state, 3'd2);
        startStopButton = 1'b0;
        tick(30);
        mode = 2'b00;
        tick(3);
        check_eq("flip_init_st", state, 3'd0);
        check_eq("flip_clr",     clrPulse, 1'b1);
        check_eq("flip_cdown",   countDown, 1'b0);
        check_eq("flip_en",      cntEn, 1'b0);
        tick(1);
        check_eq("flip_idle", state, 3'd1);

        // Short clear glitch has no effect
        clearButton = 1'b1; tick(10);
        clearButton = 1'b0; tick(40);
        check_eq("glitch_state", state, 3'd1);

        // Simultaneous clear and start from RUN: clear wins
        startStopButton = 1'b1;
        tick(23);
        check_eq("sim_run", state, 3'd2);
        startStopButton = 1'b0;
        tick(30);
        clearButton = 1'b1;
        startStopButton = 1'b1;
        tick(23);
        check_eq("sim_init", state, 3'd0);
        tick(1);
        check_eq("sim_idle", state, 3'd1);
        check_eq("sim_en",   cntEn, 1'b0);
        clearButton = 1'b0;
        startStopButton = 1'b0;
        tick(30);
        check_eq("sim_no_queue", state, 3'd1);

        // Asynchronous reset mid-run
        startStopButton = 1'b1;
        tick(23);
        check_eq("arst_run", cntEn, 1'b1);
        startStopButton = 1'b0;
        tick(30);
        #2 reset_n = 1'b0;
        #1;
        check_eq("arst_en",    cntEn, 1'b0);
        check_eq("arst_state", state, 3'd0);
        tick(1);
        reset_n = 1'b1;
        #1;
        check_eq("arst_rel_clr", clrPulse, 1'b1);
        tick(1);
        check_eq("arst_rel_idle", state, 3'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
